atom_npu_seq: RTL

//  Command sequencer for the atomNPU int8 MAC datapath inside tt_um_atomNPU.

---
 rtl/atom_npu_pkg.sv | 18 +
 rtl/atom_npu_seq_if.sv | 21 ++
 rtl/atom_npu_postproc.sv | 37 +++
 rtl/atom_npu_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/atom_npu_pkg.sv
// Shared opcodes, FSM encoding and int8 limits for the atomNPU command sequencer.
package atom_npu_pkg;

  localparam logic [3:0] OP_LOADW = 4'h1;
  localparam logic [3:0] OP_RUN   = 4'h2;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADW  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUT    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/atom_npu_seq_if.sv
// Byte command stream in and result byte out, both valid/ready handshakes.
interface atom_npu_seq_if;

  logic              cmd_valid;
  logic [7:0]        cmd_data;
  logic              cmd_ready;
  logic              res_valid;
  logic signed [7:0] res_data;
  logic              res_ready;

  modport master (
    output cmd_valid, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data
  );

endinterface

// File: rtl/atom_npu_postproc.sv
// Accumulator post-processing: arithmetic right shift, optional ReLU, int8 saturation.
module atom_npu_postproc
  import atom_npu_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic [2:0]              shift,
  input  logic                    relu,
  output logic signed [7:0]       res
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(INT8_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(INT8_MIN);

  function automatic logic signed [ACC_W-1:0] relu_clip(
    input logic signed [ACC_W-1:0] v,
    input logic                    en
  );
    return (en && v[ACC_W-1]) ? '0 : v;
  endfunction

  function automatic logic signed [7:0] sat_int8(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI) begin
      return $signed(SAT_HI[7:0]);
    end else if (v < SAT_LO) begin
      return $signed(SAT_LO[7:0]);
    end
    return $signed(v[7:0]);
  endfunction

  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc >>> shift;
  assign res     = sat_int8(relu_clip(shifted, relu));

endmodule

// File: rtl/atom_npu_seq.sv
// Command sequencer: loads the weight buffer, streams activation/weight pairs into the
// MAC, waits out the MAC latency and returns one post-processed int8 result.
module atom_npu_seq
  import atom_npu_pkg::*;
#(
  parameter int N_TAPS  = 4,
  parameter int ACC_W   = 20,
  parameter int MAC_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  atom_npu_seq_if.slave           bus,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic signed [7:0]       mac_a,
  output logic signed [7:0]       mac_b,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic                    busy
);

  localparam int CNT_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int WCNT_W = $clog2(MAC_LAT + 2);
  localparam logic [CNT_W-1:0]  TAP_LAST   = CNT_W'(N_TAPS - 1);
  localparam logic [WCNT_W-1:0] DRAIN_LAST = WCNT_W'(MAC_LAT + 1);

  seq_state_t         state;
  seq_state_t         state_nxt;
  logic [CNT_W-1:0]   tap_cnt;
  logic [WCNT_W-1:0]  wait_cnt;
  logic signed [7:0]  w [N_TAPS];
  logic [2:0]         shift_q;
  logic               relu_q;

  logic               mac_en_p1;
  logic signed [7:0]  mac_a_p1;
  logic signed [7:0]  mac_b_p1;
  logic signed [7:0]  pp_res;
  logic signed [7:0]  res_p2;

  logic [3:0]         op;
  logic               xfer;
  logic               tap_last;
  logic               drain_done;

  assign op         = bus.cmd_data[7:4];
  assign xfer       = bus.cmd_valid & bus.cmd_ready & ena;
  assign tap_last   = (tap_cnt == TAP_LAST);
  assign drain_done = (wait_cnt == DRAIN_LAST);

  // State register: ena=0 freezes the FSM in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          if (op == OP_LOADW) begin
            state_nxt = ST_LOADW;
          end else if (op == OP_RUN) begin
            state_nxt = ST_STREAM;
          end
        end
      end
      ST_LOADW:  if (xfer && tap_last) state_nxt = ST_IDLE;
      ST_STREAM: if (xfer && tap_last) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_done)       state_nxt = ST_OUT;
      ST_OUT:    if (bus.res_ready)    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // mac_clr fires in the same cycle the RUN byte is accepted.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    mac_clr       = 1'b0;
    busy          = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        mac_clr       = bus.cmd_valid & ena & (op == OP_RUN);
      end
      ST_LOADW, ST_STREAM: bus.cmd_ready = 1'b1;
      ST_OUT:              bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  // Stage p0 -> p1: accepted byte becomes a MAC operand pair; p2 holds the sampled result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_cnt   <= '0;
      wait_cnt  <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      mac_en_p1 <= 1'b0;
      mac_a_p1  <= '0;
      mac_b_p1  <= '0;
      res_p2    <= '0;
      for (int i = 0; i < N_TAPS; i++) begin
        w[i] <= '0;
      end
    end else if (ena) begin
      mac_en_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            tap_cnt <= '0;
            if (op == OP_RUN) begin
              shift_q <= bus.cmd_data[2:0];
              relu_q  <= bus.cmd_data[3];
            end
          end
        end
        ST_LOADW: begin
          if (xfer) begin
            w[tap_cnt] <= $signed(bus.cmd_data);
            tap_cnt    <= tap_last ? '0 : tap_cnt + 1'b1;
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            mac_a_p1  <= $signed(bus.cmd_data);
            mac_b_p1  <= w[tap_cnt];
            mac_en_p1 <= 1'b1;
            tap_cnt   <= tap_last ? '0 : tap_cnt + 1'b1;
            wait_cnt  <= '0;
          end
        end
        ST_DRAIN: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (drain_done) begin
            res_p2 <= pp_res;
          end
        end
        default: ;
      endcase
    end
  end

  // A pulse pending while ena is low is held and issued once ena returns.
  assign mac_en       = mac_en_p1 & ena;
  assign mac_a        = mac_a_p1;
  assign mac_b        = mac_b_p1;
  assign bus.res_data = res_p2;

  atom_npu_postproc #(
    .ACC_W (ACC_W)
  ) u_postproc (
    .acc   (acc_in),
    .shift (shift_q),
    .relu  (relu_q),
    .res   (pp_res)
  );

endmodule
